// File: rtl/dual_issue_pkg.sv
// rtl/dual_issue_pkg.sv - opcodes and RV32 field extractors shared by issue and decode
package dual_issue_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic [6:0] get_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] get_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] get_rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] get_rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

endpackage

// File: rtl/dual_issue_pair_check.sv
// rtl/dual_issue_pair_check.sv - decides whether the two oldest instructions may issue together
module dual_issue_pair_check
  import dual_issue_pkg::*;
(
  input  logic [31:0] e0_i,
  input  logic [31:0] e1_i,
  output logic        pair_ok_o
);

  logic [4:0] rd0;
  logic [6:0] op0;
  logic [6:0] op1;
  logic       raw_hit;
  logic       waw_hit;
  logic       e0_ctrl;
  logic       e1_mem;

  // Fields are taken from fixed positions regardless of format; false hazards are only conservative.
  always_comb begin
    rd0       = get_rd(e0_i);
    op0       = get_opcode(e0_i);
    op1       = get_opcode(e1_i);
    raw_hit   = (rd0 != 5'd0) && ((rd0 == get_rs1(e1_i)) || (rd0 == get_rs2(e1_i)));
    waw_hit   = (rd0 != 5'd0) && (rd0 == get_rd(e1_i));
    e0_ctrl   = (op0 == OP_BRANCH) || (op0 == OP_JAL) || (op0 == OP_JALR);
    e1_mem    = (op1 == OP_LOAD) || (op1 == OP_STORE);
    pair_ok_o = !(raw_hit || waw_hit || e0_ctrl || e1_mem);
  end

endmodule

// File: rtl/dual_issue_sched.sv
// rtl/dual_issue_sched.sv - in-order dual-issue queue between fetch and the execution pipes
module dual_issue_sched
  import dual_issue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                         Clk,
  input  logic                         RstN,
  input  logic                         flush,
  input  logic [1:0]                   in_valid,
  input  logic [31:0]                  in_instr0,
  input  logic [31:0]                  in_instr1,
  output logic                         in_ready,
  input  logic                         issue_ready,
  output logic                         issue0_valid,
  output logic [31:0]                  issue0_instr,
  output logic                         issue1_valid,
  output logic [31:0]                  issue1_instr,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]             dual_cnt,
  output logic [CNT_W-1:0]             single_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  logic [31:0]      mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [OW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] dual_q, dual_d;
  logic [CNT_W-1:0] single_q, single_d;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;
  logic [31:0]      e0;
  logic [31:0]      e1;
  logic             pair_ok;

  assign e0 = mem_q[head_q];
  assign e1 = mem_q[head_q + PW'(1)];

  dual_issue_pair_check u_pair_check (
    .e0_i      (e0),
    .e1_i      (e1),
    .pair_ok_o (pair_ok)
  );

  // Readiness uses registered count only, so fetch never waits on the backend handshake.
  assign in_ready     = (OW'(DEPTH) - count_q) >= OW'(2);
  assign issue0_valid = (count_q != '0);
  assign issue1_valid = (count_q >= OW'(2)) && pair_ok;
  assign issue0_instr = issue0_valid ? e0 : 32'h0;
  assign issue1_instr = issue1_valid ? e1 : 32'h0;
  assign occupancy    = count_q;
  assign dual_cnt     = dual_q;
  assign single_cnt   = single_q;

  // Next-state for pointers, count and statistics; flush overrides push and pop.
  always_comb begin
    push_n = 2'd0;
    pop_n  = 2'd0;
    if (!flush && in_ready && in_valid[0]) begin
      push_n = in_valid[1] ? 2'd2 : 2'd1;
    end
    if (!flush && issue_ready) begin
      pop_n = {1'b0, issue0_valid} + {1'b0, issue1_valid};
    end
    head_d   = head_q + PW'(pop_n);
    tail_d   = tail_q + PW'(push_n);
    count_d  = count_q + OW'(push_n) - OW'(pop_n);
    dual_d   = dual_q;
    single_d = single_q;
    if (pop_n == 2'd2 && dual_q != '1) begin
      dual_d = dual_q + CNT_W'(1);
    end
    if (pop_n == 2'd1 && single_q != '1) begin
      single_d = single_q + CNT_W'(1);
    end
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!RstN) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      dual_q   <= '0;
      single_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      dual_q   <= dual_d;
      single_q <= single_d;
    end
  end

  // Queue storage; contents are only observed through valid-gated outputs, so it needs no reset.
  always_ff @(posedge Clk) begin
    if (RstN && push_n != 2'd0) begin
      mem_q[tail_q] <= in_instr0;
    end
    if (RstN && push_n == 2'd2) begin
      mem_q[tail_q + PW'(1)] <= in_instr1;
    end
  end

endmodule

// File: tb/tb_dual_issue_sched.sv
// tb/tb_dual_issue_sched.sv - self-checking bench for dual_issue_sched
module tb_dual_issue_sched;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic        Clk = 1'b0;
  logic        RstN;
  logic        flush;
  logic [1:0]  in_valid;
  logic [31:0] in_instr0;
  logic [31:0] in_instr1;
  logic        in_ready;
  logic        issue_ready;
  logic        issue0_valid;
  logic [31:0] issue0_instr;
  logic        issue1_valid;
  logic [31:0] issue1_instr;
  logic [3:0]  occupancy;
  logic [CNT_W-1:0] dual_cnt;
  logic [CNT_W-1:0] single_cnt;

  dual_issue_sched #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .Clk          (Clk),
    .RstN         (RstN),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_instr0    (in_instr0),
    .in_instr1    (in_instr1),
    .in_ready     (in_ready),
    .issue_ready  (issue_ready),
    .issue0_valid (issue0_valid),
    .issue0_instr (issue0_instr),
    .issue1_valid (issue1_valid),
    .issue1_instr (issue1_instr),
    .occupancy    (occupancy),
    .dual_cnt     (dual_cnt),
    .single_cnt   (single_cnt)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mq[$];
  int          m_dual = 0;
  int          m_single = 0;

  typedef struct {
    logic        fl;
    logic [1:0]  iv;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdy;
    logic        ev0;
    logic [31:0] ei0;
    logic        ev1;
    logic [31:0] ei1;
    int          eocc;
    int          edual;
    int          esingle;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_pair(input logic [31:0] older, input logic [31:0] younger);
    logic [4:0] d;
    logic [6:0] o0;
    logic [6:0] o1;
    d  = older[11:7];
    o0 = older[6:0];
    o1 = younger[6:0];
    if (d != 0 && (d == younger[19:15] || d == younger[24:20] || d == younger[11:7])) return 0;
    if (o0 == 7'h63 || o0 == 7'h6F || o0 == 7'h67) return 0;
    if (o1 == 7'h03 || o1 == 7'h23) return 0;
    return 1;
  endfunction

  function automatic int m_issue_count();
    if (mq.size() == 0) return 0;
    if (mq.size() >= 2 && m_pair(mq[0], mq[1])) return 2;
    return 1;
  endfunction

  // Drive inputs (called right after a falling edge) and compare DUT against the model.
  task automatic drive(input bit rst, input bit fl, input logic [1:0] iv,
                       input logic [31:0] a, input logic [31:0] b, input bit rdy);
    int n;
    RstN = rst; flush = fl; in_valid = iv; in_instr0 = a; in_instr1 = b; issue_ready = rdy;
    #1;
    n = m_issue_count();
    chk("m_issue0_valid", issue0_valid, n >= 1);
    chk("m_issue0_instr", issue0_instr, (n >= 1) ? mq[0] : 32'h0);
    chk("m_issue1_valid", issue1_valid, n == 2);
    chk("m_issue1_instr", issue1_instr, (n == 2) ? mq[1] : 32'h0);
    chk("m_in_ready", in_ready, (DEPTH - mq.size()) >= 2);
    chk("m_occupancy", occupancy, mq.size());
    chk("m_dual_cnt", dual_cnt, m_dual);
    chk("m_single_cnt", single_cnt, m_single);
  endtask

  // Clock the DUT and apply the same cycle to the model.
  task automatic advance();
    int  n;
    bit  rdy_now;
    n = m_issue_count();
    rdy_now = (DEPTH - mq.size()) >= 2;
    @(posedge Clk);
    if (!RstN) begin
      mq.delete();
      m_dual = 0;
      m_single = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (issue_ready) begin
        repeat (n) void'(mq.pop_front());
        if (n == 2 && m_dual < CMAX) m_dual++;
        if (n == 1 && m_single < CMAX) m_single++;
      end
      if (rdy_now && in_valid[0]) begin
        mq.push_back(in_instr0);
        if (in_valid[1]) mq.push_back(in_instr1);
      end
    end
    @(negedge Clk);
  endtask

  task automatic step(input bit rst, input bit fl, input logic [1:0] iv,
                      input logic [31:0] a, input logic [31:0] b, input bit rdy);
    drive(rst, fl, iv, a, b, rdy);
    advance();
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] op;
    case ($urandom_range(0, 6))
      0: op = 7'h13;
      1: op = 7'h33;
      2: op = 7'h03;
      3: op = 7'h23;
      4: op = 7'h63;
      5: op = 7'h6F;
      default: op = 7'h67;
    endcase
    return {7'h0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'h0,
            5'($urandom_range(0, 3)), op};
  endfunction

  logic [31:0] first_fill;
  int          sv_dual;
  int          sv_single;

  initial begin
    tbl[0] = '{0, 2'b11, 32'h00100093, 32'h00300193, 1, 0, 32'h0,        0, 32'h0,        0, 0, 0};
    tbl[1] = '{0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h00100093, 1, 32'h00300193, 2, 0, 0};
    tbl[2] = '{0, 2'b11, 32'h00100093, 32'h00108133, 1, 0, 32'h0,        0, 32'h0,        0, 1, 0};
    tbl[3] = '{0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h00100093, 0, 32'h0,        2, 1, 0};
    tbl[4] = '{0, 2'b11, 32'h00000463, 32'h00300193, 1, 1, 32'h00108133, 0, 32'h0,        1, 1, 1};
    tbl[5] = '{0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h00000463, 0, 32'h0,        2, 1, 2};
    tbl[6] = '{0, 2'b11, 32'h00300193, 32'h00002283, 1, 1, 32'h00300193, 0, 32'h0,        1, 1, 3};
    tbl[7] = '{0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h00300193, 0, 32'h0,        2, 1, 4};
    tbl[8] = '{0, 2'b00, 32'h0,        32'h0,        1, 1, 32'h00002283, 0, 32'h0,        1, 1, 5};
    tbl[9] = '{0, 2'b00, 32'h0,        32'h0,        1, 0, 32'h0,        0, 32'h0,        0, 1, 6};

    RstN = 1'b0; flush = 1'b0; in_valid = 2'b00; in_instr0 = '0; in_instr1 = '0; issue_ready = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    RstN = 1'b1;
    #1;
    chk("reset_occupancy", occupancy, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_issue0_valid", issue0_valid, 0);
    chk("reset_issue1_valid", issue1_valid, 0);
    chk("reset_issue0_instr", issue0_instr, 0);
    chk("reset_dual_cnt", dual_cnt, 0);
    chk("reset_single_cnt", single_cnt, 0);

    // Directed pairing vectors: RAW, branch in slot 0, load in slot 1.
    for (int i = 0; i < 10; i++) begin
      drive(1, tbl[i].fl, tbl[i].iv, tbl[i].a, tbl[i].b, tbl[i].rdy);
      chk($sformatf("tbl%0d_v0", i), issue0_valid, tbl[i].ev0);
      chk($sformatf("tbl%0d_i0", i), issue0_instr, tbl[i].ei0);
      chk($sformatf("tbl%0d_v1", i), issue1_valid, tbl[i].ev1);
      chk($sformatf("tbl%0d_i1", i), issue1_instr, tbl[i].ei1);
      chk($sformatf("tbl%0d_occ", i), occupancy, tbl[i].eocc);
      chk($sformatf("tbl%0d_dual", i), dual_cnt, tbl[i].edual);
      chk($sformatf("tbl%0d_single", i), single_cnt, tbl[i].esingle);
      advance();
    end

    // Fill to full from a nonzero head so the pointers wrap, then drain in order.
    step(1, 0, 2'b01, 32'h00A00513, 32'h0, 0);
    step(1, 0, 2'b00, 32'h0, 32'h0, 1);
    first_fill = 32'h00100093;
    for (int i = 0; i < 4; i++)
      step(1, 0, 2'b11, 32'h00100093 + (i << 8), 32'h00100093 + ((i + 8) << 8), 0);
    drive(1, 0, 2'b11, 32'hDEADBEEF, 32'hCAFEF00D, 0);
    chk("full_occupancy", occupancy, DEPTH);
    chk("full_in_ready", in_ready, 0);
    chk("full_head_instr", issue0_instr, first_fill);
    advance();
    drive(1, 0, 2'b00, 32'h0, 32'h0, 0);
    chk("full_ignored_push", occupancy, DEPTH);
    advance();
    repeat (8) step(1, 0, 2'b00, 32'h0, 32'h0, 1);

    // Flush with six queued and a pair offered in the same cycle.
    for (int i = 0; i < 3; i++) step(1, 0, 2'b11, rnd_instr(), rnd_instr(), 0);
    sv_dual = m_dual;
    sv_single = m_single;
    drive(1, 1, 2'b11, 32'h00100093, 32'h00300193, 1);
    chk("preflush_occupancy", occupancy, 6);
    advance();
    drive(1, 0, 2'b00, 32'h0, 32'h0, 0);
    chk("flush_occupancy", occupancy, 0);
    chk("flush_issue0_valid", issue0_valid, 0);
    chk("flush_issue1_valid", issue1_valid, 0);
    chk("flush_dual_cnt", dual_cnt, sv_dual);
    chk("flush_single_cnt", single_cnt, sv_single);
    advance();

    // Saturation: keep dual issuing well past the 4-bit counter limit.
    for (int i = 0; i < 20; i++) step(1, 0, 2'b11, 32'h00100093, 32'h00300193, 1);
    repeat (2) step(1, 0, 2'b00, 32'h0, 32'h0, 1);
    drive(1, 0, 2'b00, 32'h0, 32'h0, 1);
    chk("sat_dual_cnt", dual_cnt, 4'hF);
    advance();

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++)
      step(1, ($urandom_range(0, 31) == 0), 2'($urandom_range(0, 3)), rnd_instr(), rnd_instr(),
           ($urandom_range(0, 3) != 0));

    // Mid-stream reset with a nonempty queue.
    step(1, 0, 2'b11, 32'h00100093, 32'h00300193, 0);
    step(0, 0, 2'b11, 32'h00100093, 32'h00300193, 1);
    drive(1, 0, 2'b00, 32'h0, 32'h0, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_issue0_valid", issue0_valid, 0);
    chk("rst_issue0_instr", issue0_instr, 0);
    chk("rst_dual_cnt", dual_cnt, 0);
    chk("rst_single_cnt", single_cnt, 0);
    advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dual_issue_sched.md
Name: dual_issue_sched

Overview:
In-order issue scheduler that feeds the dual-issue decode stage.
- Buffers fetched instructions, up to 2 per cycle, in a circular queue.
- Each cycle, presents the oldest entry on slot 0 and the next-oldest on slot 1 when the pair is legal under the dual-issue pairing rules.
- Pops 0, 1 or 2 entries on backend acceptance. An unpaired second instruction stays queued and re-issues as next cycle's slot 0, so nothing is dropped or zeroed.
- Sits between fetch and the execution pipes.
- Keeps saturating single/dual issue statistics.

Parameters:
DEPTH, 8, queue entries; power of 2, minimum 4.
CNT_W, 32, width of issue statistics counters.

Ports:
Clk  in  1  clock
RstN  in  1  reset
flush  in  1  discard all queued instructions (branch redirect)
in_valid  in  2  bit0: in_instr0 valid; bit1: in_instr1 valid, honoured only when bit0=1
in_instr0  in  32  older fetched instruction
in_instr1  in  32  younger fetched instruction
in_ready  out  1  queue can accept 2 instructions this cycle
issue_ready  in  1  backend accepts the current issue bundle
issue0_valid  out  1  slot 0 (primary/memory pipe) holds an instruction
issue0_instr  out  32  slot 0 instruction; 32'h0 when not valid
issue1_valid  out  1  slot 1 (ALU-only pipe) holds an instruction
issue1_instr  out  32  slot 1 instruction; 32'h0 when not valid
occupancy  out  $clog2(DEPTH+1)  entries currently queued
dual_cnt  out  CNT_W  accepted bundles with 2 instructions
single_cnt  out  CNT_W  accepted bundles with exactly 1 instruction

Behaviour:
Clock and reset:
- Single clock Clk; reset RstN is synchronous, active-low.
- In reset: head, tail and count = 0; dual_cnt = single_cnt = 0; in_ready = 1; issue0_valid = issue1_valid = 0; instr outputs 32'h0.

Queue and push:
- Circular buffer with log2(DEPTH)-bit head/tail pointers that wrap modulo DEPTH, plus a separate count (full vs empty is decided by count, never by pointer equality).
- in_ready = (DEPTH - count) >= 2, from registered count only; it does not depend on same-cycle pop.
- Push occurs when in_ready=1. Push amount: in_valid=2'b01 -> 1, 2'b11 -> 2, 2'b00 or 2'b10 -> 0.
- When in_ready=0, inputs are ignored; fetch must hold them.
- Latency: a pushed instruction is visible on issue outputs the cycle after push. There is no same-cycle bypass.

Issue selection (combinational from queue head):
- E0 = entry[head], E1 = entry[head+1 mod DEPTH].
- issue0_valid = count >= 1.
- issue1_valid = count >= 2 AND pair_ok(E0, E1).
- pair_ok is false if any of:
  - RAW: rd(E0) != 0 and rd(E0) equals rs1(E1) or rs2(E1).
  - WAW: rd(E0) != 0 and rd(E0) == rd(E1).
  - E0 opcode is branch 1100011, jal 1101111 or jalr 1100111.
  - E1 opcode is load 0000011 or store 0100011.
- rd/rs1/rs2 come from the standard RV32 fields [11:7]/[19:15]/[24:20] regardless of format.
- Order is never swapped: slot 0 is always the oldest entry.

Pop and statistics:
- pop = issue_ready ? (issue0_valid + issue1_valid) : 0; head advances by pop.
- count_next = count + push - pop. Simultaneous push and pop are legal, including when full (count=DEPTH-2 plus 2 pushed and 2 popped).
- Counters update on accepted bundles: pop=2 -> dual_cnt+1; pop=1 -> single_cnt+1. Both saturate at all-ones.

Flush:
- Highest priority: the cycle flush=1, push and pop are suppressed; next cycle head = tail = count = 0.
- Counters are not cleared by flush.
- Output valids drop the cycle after flush.

Decomposition:
- Shared package dual_issue_pkg:
  - opcode localparams OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR;
  - field-extract functions get_rd, get_rs1, get_rs2, get_opcode.
- Sub-module dual_issue_pair_check (pure combinational: E0, E1 -> pair_ok) so the pairing rule is shared with the decode stage.
- Queue storage, pointers and counters stay in the top.

Test Plan:
1. Push 0x00100093 (addi x1,x0,1) + 0x00300193 (addi x3,x0,3), issue_ready=1 -> next cycle both valid, slot0=0x00100093, slot1=0x00300193; then occupancy 0, dual_cnt=1.
2. Push 0x00100093 + 0x00108133 (add x2,x1,x1) -> issue1_valid=0 (RAW), single_cnt=1; following cycle slot0=0x00108133.
3. Push 0x00000463 (beq) + 0x00300193 -> single issue of beq. Separately push 0x00300193 + 0x00002283 (lw) -> addi issues alone, then lw issues on slot 0.
4. Push 2/cycle with issue_ready=0 for DEPTH/2 cycles -> occupancy=DEPTH, in_ready=0; extra pushes ignored. Release issue_ready -> FIFO order preserved across pointer wrap.
5. Queue holds 6, assert flush with in_valid=2'b11 -> next cycle occupancy=0, issue valids 0, pushed pair discarded, counters unchanged.
6. Mid-stream RstN=0 for one cycle -> all outputs at reset values next cycle; force counter near all-ones -> saturates, no wrap.
